key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
// - Cleans one raw mechanical push-button input (asynchronous, bouncy) for the stopwatch front end.
// - Output key_out drives the stopwatch pause input. That input toggles run/stop on a falling edge, so key_out must be glitch-free.
// - Also gives one-cycle press/release strobes and an optional long-press strobe, for a future lap/clear function.
// - Sits directly upstream of the stopwatch top level. One instance per button.
// PARAMETERS
// - CLK_HZ       50_000_000  clock frequency in Hz
// - DEBOUNCE_MS  20          stable time required to accept a level change, in ms
// - LONG_MS      1000        hold time, measured after press acceptance, that fires long_press
// - KEY_IDLE     1'b1        level of key_in when not pressed (board keys are active-low)
// PORTS
// - clk_50M        in   1  system clock, 50 MHz
// - rst            in   1  asynchronous reset, active-low
// - key_in         in   1  raw button; asynchronous to clk_50M
// - key_out        out  1  debounced level; same polarity as key_in
// - press_pulse    out  1  1-cycle strobe when a press is accepted
// - release_pulse  out  1  1-cycle strobe when a release is accepted
// - long_press     out  1  1-cycle strobe after LONG_MS of continuous accepted hold
// BEHAVIOUR
// - Derived constants:
//   - DB_CNT = CLK_HZ/1000*DEBOUNCE_MS. Require DB_CNT >= 2; at default this is 1_000_000.
//   - LONG_CNT = CLK_HZ/1000*LONG_MS.
//   - Counter widths come from $clog2 of these constants.
// - Synchronizer: 2-FF chain sync1 -> sync2 on key_in. Both flops reset to KEY_IDLE. All logic below uses sync2 only.
// - Reset (rst=0) forces, asynchronously:
//   - key_out=KEY_IDLE
//   - press_pulse=0, release_pulse=0, long_press=0
//   - state=IDLE, counters=0
// - FSM, evaluated every clock edge:
//   - IDLE: sync2!=KEY_IDLE -> PRESS_WAIT, db_cnt=0.
//   - PRESS_WAIT:
//     - sync2==KEY_IDLE -> IDLE. Bounce rejected; no strobe.
//     - Otherwise db_cnt++.
//     - On the DB_CNT-th consecutive active sample -> PRESSED, key_out<=~KEY_IDLE, press_pulse=1 for 1 cycle.
//   - PRESSED: sync2==KEY_IDLE -> RELEASE_WAIT, db_cnt=0.
//   - RELEASE_WAIT:
//     - sync2!=KEY_IDLE -> PRESSED. Release rejected; key_out unchanged; long timer resumes, not restarted.
//     - On the DB_CNT-th consecutive idle sample -> IDLE, key_out<=KEY_IDLE, release_pulse=1 for 1 cycle.
// - Latency: key_out changes DB_CNT+2 clock edges after key_in settles. The +2 is the synchronizer.
// - Strobes are registered and never overlap. press_pulse and key_out assert on the same edge.
// - Counters never wrap. db_cnt clears on every state entry. A bounce resets the qualification window completely.
// - Key held through reset release: sync2 starts at KEY_IDLE, so the key is re-qualified and press_pulse fires once.
// - Reset mid-qualification discards partial counts. No strobe is emitted for an aborted window.
// CONFIGURATION
// - Macro: KEY_DEBOUNCE_LONG_PRESS_EN
// - Defined:
//   - long_cnt starts at 0 on press acceptance and counts while in PRESSED or RELEASE_WAIT.
//   - When long_cnt reaches LONG_CNT, long_press=1 for 1 cycle, once per press. The counter then saturates.
//   - long_cnt clears on return to IDLE.
// - Undefined: long_press is tied to 1'b0. No long counter is synthesized. The port list is unchanged.
// TESTING (sim override CLK_HZ=1000 -> 1 ms per cycle; DB_CNT=20; LONG_MS=100 -> LONG_CNT=100)
// - T1 reset hold:
//   - Stimulus: rst=0, key_in=0 for 5 cycles.
//   - Response: key_out=1 and all strobes 0.
//   - Then release rst with key_in=0: press_pulse exactly once, 22 edges later; key_out=0 on the same edge.
// - T2 bounce:
//   - Stimulus: key_in 0 for 10 cycles, 1 for 3 cycles, then 0 held.
//   - Response: no strobe from the first burst; single press_pulse 22 edges after the final falling edge.
// - T3 release:
//   - Stimulus: from PRESSED, key_in=1 held.
//   - Response: release_pulse once, 22 edges later; key_out=1.
// - T4 glitch while pressed:
//   - Stimulus: key_in 1 for 5 cycles, then back to 0.
//   - Response: key_out stays 0; no strobe of any kind.
// - T5 long press (macro defined):
//   - Stimulus: hold key_in=0 for 150 cycles.
//   - Response: one long_press, 100 cycles after press_pulse; none afterwards.
//   - Same stimulus, macro undefined: long_press stays 0 throughout.
// - T6 reset mid-window:
//   - Stimulus: rst=0 for 1 cycle at db_cnt=10 in PRESS_WAIT, key_in=0 held.
//   - Response: key_out=1, no strobe; press_pulse 22 edges after rst rises.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button debouncer (2-FF sync + qualify FSM); key_out and strobes land DB_CNT+2 clocks after key_in settles, no backpressure.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press counter; otherwise long_press is tied low.
module key_debounce #(
    parameter int   CLK_HZ      = 50_000_000,
    parameter int   DEBOUNCE_MS = 20,
    parameter int   LONG_MS     = 1000,
    parameter logic KEY_IDLE    = 1'b1
) (
    input  logic clk_50M,
    input  logic rst,
    input  logic key_in,
    output logic key_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int DB_CNT = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DB_W   = (DB_CNT > 2) ? $clog2(DB_CNT) : 1;
    // The transition out of IDLE/PRESSED is the first qualifying sample, so the window closes at count DB_CNT-2.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CNT - 2);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              sync1_q, sync2_q;
    logic              key_out_q, key_out_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              active;

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            sync1_q <= KEY_IDLE;
            sync2_q <= KEY_IDLE;
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    assign active = (sync2_q != KEY_IDLE);

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        key_out_d = key_out_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (active) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!active) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = PRESSED;
                    db_cnt_d  = '0;
                    key_out_d = ~KEY_IDLE;
                    press_d   = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!active) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (active) begin
                    state_d  = PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    db_cnt_d  = '0;
                    key_out_d = KEY_IDLE;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                db_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            db_cnt_q  <= '0;
            key_out_q <= KEY_IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            key_out_q <= key_out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_out       = key_out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam int LONG_CNT = CLK_HZ / 1000 * LONG_MS;
    localparam int LONG_W   = $clog2(LONG_CNT + 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_q, long_d;
    logic              held;

    assign held = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

    // Suppressed on the release edge so the strobe never overlaps release_pulse.
    always_comb begin
        long_cnt_d = long_cnt_q;
        long_d     = 1'b0;
        if (state_d == IDLE) begin
            long_cnt_d = '0;
        end else if (held && (long_cnt_q != LONG_MAX)) begin
            long_cnt_d = long_cnt_q + LONG_W'(1);
            long_d     = (long_cnt_q == LONG_LAST);
        end
    end

    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            long_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            long_cnt_q <= long_cnt_d;
            long_q     <= long_d;
        end
    end

    assign long_press = long_q;
`else
    // LONG_MS only matters when the long-press counter is built.
    logic unused_long_ms;
    assign unused_long_ms = ^LONG_MS;
    assign long_press     = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce at CLK_HZ=1000 (DB_CNT=20, LONG_CNT=100): directed scenarios then random bursts vs a run-length model.
module tb_key_debounce;

    localparam int DB   = 20;
    localparam int LONG = 100;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk_50M = 1'b0;
    logic rst     = 1'b0;
    logic key_in  = 1'b0;
    logic key_out, press_pulse, release_pulse, long_press;

    int tests = 0;
    int fails = 0;

    // Reference model: synchronizer delay line plus a run length of samples disagreeing with key_out.
    logic m_s1, m_s2, m_key, m_press, m_rel, m_long;
    int   m_run, m_hold;

    key_debounce #(
        .CLK_HZ     (1000),
        .DEBOUNCE_MS(20),
        .LONG_MS    (100),
        .KEY_IDLE   (1'b1)
    ) dut (
        .clk_50M      (clk_50M),
        .rst          (rst),
        .key_in       (key_in),
        .key_out      (key_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (!rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_key = 1'b1; m_run = 0; m_hold = 0;
        end else begin
            if (m_s2 != m_key) begin
                m_run++;
                if (m_run == DB) begin
                    m_key   = ~m_key;
                    m_run   = 0;
                    m_press = (m_key == 1'b0);
                    m_rel   = (m_key == 1'b1);
                end
            end else begin
                m_run = 0;
            end
            if (m_key == 1'b1 || m_press) begin
                m_hold = 0;
            end else if (m_hold < LONG) begin
                m_hold++;
                m_long = LONG_EN && (m_hold == LONG);
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        model_step();
        #1;
        chk("key_out", key_out, m_key);
        chk("press_pulse", press_pulse, m_press);
        chk("release_pulse", release_pulse, m_rel);
        chk("long_press", long_press, m_long);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return press_pulse;
            1:       return release_pulse;
            default: return long_press;
        endcase
    endfunction

    // Ticks until the selected strobe is seen; n = ticks taken, or -1 if the bound expires.
    task automatic wait_for(input int sel, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            tick();
            if (pick(sel)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, cnt, at;
        m_s1 = 1'b1; m_s2 = 1'b1; m_key = 1'b1; m_run = 0; m_hold = 0;
        m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;

        // T1: reset hold with key pressed, then release reset
        for (int i = 0; i < 5; i++) tick();
        chk("t1_reset_key_out", key_out, 1'b1);
        chk("t1_reset_press", press_pulse, 1'b0);
        rst = 1'b1;
        wait_for(0, 100, n);
        chk_int("t1_press_latency", n, 22);
        chk("t1_key_out_with_press", key_out, 1'b0);

        // T3: release from PRESSED
        key_in = 1'b1;
        wait_for(1, 100, n);
        chk_int("t3_release_latency", n, 22);
        chk("t3_key_out", key_out, 1'b1);

        // T2: short active burst, brief idle, then held
        cnt = 0;
        key_in = 1'b0;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(press_pulse); end
        key_in = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); cnt += int'(press_pulse); end
        key_in = 1'b0;
        wait_for(0, 100, n);
        chk_int("t2_burst_press_count", cnt, 0);
        chk_int("t2_press_latency", n, 22);

        // T4: release glitch while pressed
        cnt = 0;
        key_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(); cnt += int'(press_pulse) + int'(release_pulse);
        end
        key_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(); cnt += int'(press_pulse) + int'(release_pulse);
        end
        chk_int("t4_strobe_count", cnt, 0);
        chk("t4_key_out", key_out, 1'b0);

        // T5: fresh press held for 150 cycles
        key_in = 1'b1;
        wait_for(1, 100, n);
        chk_int("t5_release_latency", n, 22);
        key_in = 1'b0;
        wait_for(0, 100, n);
        chk_int("t5_press_latency", n, 22);
        cnt = 0;
        at  = -1;
        for (int i = 1; i <= 150; i++) begin
            tick();
            if (long_press) begin
                cnt++;
                if (at < 0) at = i;
            end
        end
        chk_int("t5_long_count", cnt, LONG_EN ? 1 : 0);
        chk_int("t5_long_offset", at, LONG_EN ? LONG : -1);

        // T6: reset pulse at db_cnt=10 in PRESS_WAIT
        key_in = 1'b1;
        wait_for(1, 100, n);
        chk_int("t6_release_latency", n, 22);
        key_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin tick(); cnt += int'(press_pulse); end
        rst = 1'b0;
        tick();
        chk("t6_reset_key_out", key_out, 1'b1);
        rst = 1'b1;
        wait_for(0, 100, n);
        chk_int("t6_aborted_press_count", cnt, 0);
        chk_int("t6_press_latency", n, 22);

        // Random bursts with occasional resets, checked every cycle by the model
        for (int seg = 0; seg < 60; seg++) begin
            int len;
            key_in = 1'($urandom_range(0, 1));
            len    = int'($urandom_range(1, 35));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            for (int i = 0; i < len; i++) tick();
        end
        key_in = 1'b0;
        for (int i = 0; i < 130; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
